// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter and anything that models it.
package div_pkg;

  localparam int DIV_W = 16;

  // Quotients returned for a divide by zero with a positive / negative dividend.
  localparam logic [DIV_W-1:0] DBZ_Q_POS = 16'h7FFF;
  localparam logic [DIV_W-1:0] DBZ_Q_NEG = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RESPOND = 3'd3,
    ST_RECOVER = 3'd4
  } div_arb_state_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Four-phase handshake between the arbiter (master) and the shared divider (slave).
interface div_arbiter_if;
  import div_pkg::*;

  logic             div_req;
  logic             div_rst;
  logic [DIV_W-1:0] div_a;
  logic [DIV_W-1:0] div_d;
  logic             div_ack;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_r;
  logic             div_fdbz;

  modport master (
    output div_req, div_rst, div_a, div_d,
    input  div_ack, div_q, div_r, div_fdbz
  );

  modport slave (
    input  div_req, div_rst, div_a, div_d,
    output div_ack, div_q, div_r, div_fdbz
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which keeps this purely combinational (no latch).
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      logic [IW-1:0] pos;
      pos = IW'((int'(ptr_i) + k) % N);
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential signed divider among N requesters: round-robin grant,
// divider handshake, result latching and a watchdog that resets a stuck divider.
module div_arbiter
  import div_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 40,
  localparam int IW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_i,
  input  logic [DIV_W*N-1:0] a_i,
  input  logic [DIV_W*N-1:0] d_i,
  output logic [N-1:0]       ack_o,
  output logic [DIV_W-1:0]   q_o,
  output logic [DIV_W-1:0]   r_o,
  output logic               fdbz_o,
  output logic               tout_o,
  output logic [IW-1:0]      gnt_o,
  div_arbiter_if.master      div_if
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_ISSUE   = ST_ISSUE;
  localparam logic [2:0] S_DRAIN   = ST_DRAIN;
  localparam logic [2:0] S_RESPOND = ST_RESPOND;
  localparam logic [2:0] S_RECOVER = ST_RECOVER;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic             fdbz_q, fdbz_d;
  logic             tout_q, tout_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic             div_req_q, div_req_d;
  logic             div_rst_q, div_rst_d;
  logic [DIV_W-1:0] op_a_q, op_a_d;
  logic [DIV_W-1:0] op_d_q, op_d_d;

  logic [DIV_W-1:0] a_arr [N];
  logic [DIV_W-1:0] d_arr [N];
  logic [N-1:0]     pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             wdog_exp;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign a_arr[g] = a_i[g*DIV_W +: DIV_W];
    assign d_arr[g] = d_i[g*DIV_W +: DIV_W];
  end

  rr_pick #(.N(N)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx)
  );

  assign wdog_exp = (wdog_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    ack_d     = ack_q;
    q_d       = q_q;
    r_d       = r_q;
    fdbz_d    = fdbz_q;
    tout_d    = tout_q;
    gnt_d     = gnt_q;
    div_req_d = div_req_q;
    div_rst_d = 1'b0;
    op_a_d    = op_a_q;
    op_d_d    = op_d_q;

    unique case (state_q)
      S_IDLE: begin
        if (|pick_oh) begin
          gnt_d     = pick_idx;
          op_a_d    = a_arr[pick_idx];
          op_d_d    = d_arr[pick_idx];
          div_req_d = 1'b1;
          wdog_d    = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (div_if.div_ack) begin
          q_d       = div_if.div_q;
          r_d       = div_if.div_r;
          fdbz_d    = div_if.div_fdbz;
          tout_d    = 1'b0;
          div_req_d = 1'b0;
          wdog_d    = '0;
          state_d   = S_DRAIN;
        end else if (wdog_exp) begin
          div_req_d = 1'b0;
          div_rst_d = 1'b1;
          state_d   = S_RECOVER;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!div_if.div_ack) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = S_RESPOND;
        end else if (wdog_exp) begin
          div_rst_d = 1'b1;
          state_d   = S_RECOVER;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      // Divider reset pulse is on the wire during this single cycle.
      S_RECOVER: begin
        q_d          = '0;
        r_d          = '0;
        fdbz_d       = 1'b0;
        tout_d       = 1'b1;
        ack_d[gnt_q] = 1'b1;
        state_d      = S_RESPOND;
      end
      S_RESPOND: begin
        if (!req_i[gnt_q]) begin
          ack_d   = '0;
          ptr_d   = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      wdog_q    <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      fdbz_q    <= 1'b0;
      tout_q    <= 1'b0;
      gnt_q     <= '0;
      div_req_q <= 1'b0;
      div_rst_q <= 1'b0;
      op_a_q    <= '0;
      op_d_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      r_q       <= r_d;
      fdbz_q    <= fdbz_d;
      tout_q    <= tout_d;
      gnt_q     <= gnt_d;
      div_req_q <= div_req_d;
      div_rst_q <= div_rst_d;
      op_a_q    <= op_a_d;
      op_d_q    <= op_d_d;
    end
  end

  assign ack_o          = ack_q;
  assign q_o            = q_q;
  assign r_o            = r_q;
  assign fdbz_o         = fdbz_q;
  assign tout_o         = tout_q;
  assign gnt_o          = gnt_q;
  assign div_if.div_req = div_req_q;
  assign div_if.div_rst = div_rst_q;
  assign div_if.div_a   = op_a_q;
  assign div_if.div_d   = op_d_q;

endmodule
